// File: rtl/ex_operand_stage.sv
// Registered operand-select issue stage ahead of the execute ALU, with a one-entry skid buffer.
// Optional macro EX_OPERAND_FWD_EN enables writeback-to-operand forwarding on accept.
module ex_operand_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    rs2_data,
  input  logic [RADDR_W-1:0] rs1_addr,
  input  logic [RADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    imm,
  input  logic [1:0]         op_a_sel,
  input  logic               op_b_sel,
  input  logic [3:0]         alu_op,
  input  logic [RADDR_W-1:0] rd_addr,
  input  logic               wb_valid,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    operand_a,
  output logic [XLEN-1:0]    operand_b,
  output logic [1:0]         logic_sel,
  output logic [3:0]         alu_op_q,
  output logic [RADDR_W-1:0] rd_addr_q
);

  typedef struct packed {
    logic [XLEN-1:0]    a;
    logic [XLEN-1:0]    b;
    logic [1:0]         lsel;
    logic [3:0]         op;
    logic [RADDR_W-1:0] rd;
  } payload_t;

  localparam payload_t PAYLOAD_RST = '{a: '0, b: '0, lsel: 2'b11, op: '0, rd: '0};

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  payload_t        in_pl;
  payload_t        out_q;
  payload_t        skid_q;
  logic            skid_valid;
  logic            accept;
  logic            out_free;

`ifdef EX_OPERAND_FWD_EN
  always_comb begin
    rs1_fwd = rs1_data;
    rs2_fwd = rs2_data;
    if (wb_valid && (wb_rd != '0) && (wb_rd == rs1_addr)) rs1_fwd = wb_data;
    if (wb_valid && (wb_rd != '0) && (wb_rd == rs2_addr)) rs2_fwd = wb_data;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{rs1_addr, rs2_addr, wb_valid, wb_rd, wb_data};
  assign rs1_fwd    = rs1_data;
  assign rs2_fwd    = rs2_data;
`endif

  always_comb begin
    in_pl    = PAYLOAD_RST;
    unique case (op_a_sel)
      2'b00:   in_pl.a = rs1_fwd;
      2'b01:   in_pl.a = pc;
      default: in_pl.a = '0;
    endcase
    in_pl.b  = op_b_sel ? imm : rs2_fwd;
    unique case (alu_op[2:0])
      3'b111:  in_pl.lsel = 2'b00;
      3'b110:  in_pl.lsel = 2'b01;
      3'b100:  in_pl.lsel = 2'b10;
      default: in_pl.lsel = 2'b11;
    endcase
    in_pl.op = alu_op;
    in_pl.rd = rd_addr;
  end

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  // Skid is only ever occupied while the output register is stalled, so
  // in_ready=!skid_valid already blocks any accept on the drain cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= PAYLOAD_RST;
      skid_q     <= PAYLOAD_RST;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_q     <= in_pl;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= in_pl;
      skid_valid <= 1'b1;
    end
  end

  assign operand_a = out_q.a;
  assign operand_b = out_q.b;
  assign logic_sel = out_q.lsel;
  assign alu_op_q  = out_q.op;
  assign rd_addr_q = out_q.rd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized and directed bench for ex_operand_stage; reference is a 2-deep in-order queue
// whose entries are computed from the operand/decode rules.
module tb_ex_operand_stage;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RADDR_W = 5;
  localparam int unsigned ITEM_W  = 2 * XLEN + 2 + 4 + RADDR_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    rs1_data, rs2_data, pc, imm, wb_data;
  logic [RADDR_W-1:0] rs1_addr, rs2_addr, rd_addr, wb_rd;
  logic [1:0]         op_a_sel;
  logic               op_b_sel;
  logic [3:0]         alu_op;
  logic               wb_valid;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    operand_a, operand_b;
  logic [1:0]         logic_sel;
  logic [3:0]         alu_op_q;
  logic [RADDR_W-1:0] rd_addr_q;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [ITEM_W-1:0] exp_q[$];

  ex_operand_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .pc(pc), .imm(imm), .op_a_sel(op_a_sel), .op_b_sel(op_b_sel), .alu_op(alu_op),
    .rd_addr(rd_addr), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .operand_a(operand_a),
    .operand_b(operand_b), .logic_sel(logic_sel), .alu_op_q(alu_op_q), .rd_addr_q(rd_addr_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Instruction as the ALU should see it, built from the current input fields.
  function automatic logic [ITEM_W-1:0] ref_item();
    logic [XLEN-1:0] s1, s2, a, b;
    logic [1:0]      ls;
    s1 = rs1_data;
    s2 = rs2_data;
`ifdef EX_OPERAND_FWD_EN
    if (wb_valid && wb_rd != 0 && wb_rd == rs1_addr) s1 = wb_data;
    if (wb_valid && wb_rd != 0 && wb_rd == rs2_addr) s2 = wb_data;
`endif
    a = (op_a_sel == 2'd0) ? s1 : (op_a_sel == 2'd1) ? pc : 0;
    b = op_b_sel ? imm : s2;
    if (alu_op[2:0] == 3'b111)      ls = 2'b00;
    else if (alu_op[2:0] == 3'b110) ls = 2'b01;
    else if (alu_op[2:0] == 3'b100) ls = 2'b10;
    else                            ls = 2'b11;
    return {a, b, ls, alu_op, rd_addr};
  endfunction

  task automatic compare_outputs();
    check("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
    check("in_ready", 128'(in_ready), 128'(exp_q.size() < 2));
    if (exp_q.size() > 0)
      check("payload", 128'({operand_a, operand_b, logic_sel, alu_op_q, rd_addr_q}), 128'(exp_q[0]));
  endtask

  // Inputs are set by the caller right after a negedge; advance one clock and compare.
  task automatic step();
    bit acc, con, fl;
    logic [ITEM_W-1:0] it;
    acc = in_valid && (exp_q.size() < 2);
    con = (exp_q.size() > 0) && out_ready;
    fl  = flush;
    it  = ref_item();
    @(posedge clk);
    if (fl) exp_q.delete();
    else begin
      if (con) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(it);
    end
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; rs1_data = 0; rs2_data = 0; rs1_addr = 0; rs2_addr = 0;
    pc = 0; imm = 0; op_a_sel = 0; op_b_sel = 0; alu_op = 0; rd_addr = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0; out_ready = 1;
  endtask

  task automatic rand_inputs();
    in_valid  = ($urandom_range(0, 3) != 0);
    out_ready = ($urandom_range(0, 2) != 0);
    flush     = ($urandom_range(0, 31) == 0);
    rs1_data  = $urandom; rs2_data = $urandom; pc = $urandom; imm = $urandom;
    rs1_addr  = RADDR_W'($urandom_range(0, 3));
    rs2_addr  = RADDR_W'($urandom_range(0, 3));
    wb_rd     = RADDR_W'($urandom_range(0, 3));
    wb_valid  = $urandom_range(0, 1) != 0;
    wb_data   = $urandom;
    op_a_sel  = 2'($urandom_range(0, 3));
    op_b_sel  = $urandom_range(0, 1) != 0;
    alu_op    = 4'($urandom_range(0, 15));
    rd_addr   = RADDR_W'($urandom);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 0);
    check("rst_in_ready", 128'(in_ready), 1);
    check("rst_operand_a", 128'(operand_a), 0);
    check("rst_logic_sel", 128'(logic_sel), 3);
    check("rst_rd_addr_q", 128'({alu_op_q, rd_addr_q}), 0);
    rst_n = 1;

    // AND with immediate
    in_valid = 1; rs1_data = 32'hF0F0_F0F0; imm = 32'h0000_FFFF; op_b_sel = 1; alu_op = 4'b0111;
    step();
    check("andi_valid", 128'(out_valid), 1);
    check("andi_a", 128'(operand_a), 128'h F0F0_F0F0);
    check("andi_b", 128'(operand_b), 128'h 0000_FFFF);
    check("andi_lsel", 128'(logic_sel), 0);

    // Operand sources and decode
    op_a_sel = 2'b01; pc = 32'h0000_1000; alu_op = 4'b0100;
    step();
    check("src_pc", 128'(operand_a), 128'h1000);
    check("lsel_xor", 128'(logic_sel), 2);
    op_a_sel = 2'b10; alu_op = 4'b0000;
    step();
    check("src_zero", 128'(operand_a), 0);
    check("lsel_none", 128'(logic_sel), 3);
    in_valid = 0;
    step();

    // Back-pressure: A to output, B to skid, C held
    idle_inputs(); out_ready = 0; in_valid = 1;
    rs1_data = 32'hA; step();
    rs1_data = 32'hB; step();
    check("bp_in_ready", 128'(in_ready), 0);
    rs1_data = 32'hC; step();
    check("bp_hold_a", 128'(operand_a), 128'hA);
    out_ready = 1; step();
    check("bp_deliver_b", 128'(operand_a), 128'hB);
    step();
    check("bp_deliver_c", 128'(operand_a), 128'hC);
    check("bp_no_gap", 128'(out_valid), 1);
    in_valid = 0; step();
    check("bp_drained", 128'(out_valid), 0);

    // Flush with a full skid and a concurrent input
    out_ready = 0; in_valid = 1; rs1_data = 32'h11; step();
    rs1_data = 32'h22; step();
    flush = 1; rs1_data = 32'h33; step();
    check("flush_valid", 128'(out_valid), 0);
    check("flush_ready", 128'(in_ready), 1);
    flush = 0; in_valid = 0; out_ready = 1;
    repeat (3) step();

    // Forwarding from writeback
    in_valid = 1; wb_valid = 1; wb_rd = 5; wb_data = 32'h1234_5678; rs1_addr = 5; rs1_data = 0;
    op_a_sel = 0; step();
`ifdef EX_OPERAND_FWD_EN
    check("fwd_hit", 128'(operand_a), 128'h1234_5678);
`else
    check("fwd_off", 128'(operand_a), 0);
`endif
    wb_rd = 0; rs1_addr = 0; step();
    check("fwd_x0", 128'(operand_a), 0);
    in_valid = 0; step();

    // Async reset between edges
    idle_inputs(); in_valid = 1; rs1_data = 32'hDEAD; step();
    check("ar_pre_valid", 128'(out_valid), 1);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    check("ar_valid", 128'(out_valid), 0);
    check("ar_operand_a", 128'(operand_a), 0);
    check("ar_in_ready", 128'(in_ready), 1);
    exp_q.delete();
    #1 rst_n = 1;
    @(negedge clk);
    compare_outputs();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
